// File: rtl/axis_sample_pair_packer.sv
// Packs two narrow AXI-Stream samples per 32-bit beat, one per 16-bit lane.
// Forwards tlast, flags half-filled tails via tkeep and checks packet length.
module axis_sample_pair_packer #(
    parameter int IN_WIDTH   = 9,
    parameter int LANE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [15:0]             confi,
    input  logic [IN_WIDTH-1:0]     s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [2*LANE_WIDTH-1:0] m_axis_tdata,
    output logic [3:0]              m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    len_err,
    output logic [15:0]             pkt_count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    localparam logic [8:0] CNT_MAX = 9'd511;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IN_WIDTH-1:0]       r_held;
    logic [8:0]                r_cnt;
    logic [7:0]                r_exp_len;
    logic [2*LANE_WIDTH-1:0]   r_tdata;
    logic [3:0]                r_tkeep;
    logic                      r_tvalid;
    logic                      r_tlast;
    logic                      r_len_err;
    logic [15:0]               r_pkt_count;

    logic                      w_out_ready;
    logic                      w_accept;
    logic                      w_load;
    logic [2*LANE_WIDTH-1:0]   w_word_nxt;
    logic [3:0]                w_keep_nxt;
    logic                      w_last_nxt;
    logic [LANE_WIDTH-1:0]     w_lane_in;
    logic [LANE_WIDTH-1:0]     w_lane_held;
    logic                      w_first;
    logic [7:0]                w_exp_len;
    logic [9:0]                w_cnt_p1;
    logic                      w_mismatch;
    logic                      w_unused_confi;

    assign w_out_ready    = !r_tvalid | m_axis_tready;
    assign s_axis_tready  = w_out_ready;
    assign w_accept       = s_axis_tvalid & w_out_ready;
    assign w_lane_in      = LANE_WIDTH'(s_axis_tdata);
    assign w_lane_held    = LANE_WIDTH'(r_held);
    assign w_unused_confi = ^confi[15:8];

    // A single-sample packet must be checked against the live length value.
    assign w_first    = (r_cnt == 9'd0);
    assign w_exp_len  = w_first ? confi[7:0] : r_exp_len;
    assign w_cnt_p1   = {1'b0, r_cnt} + 10'd1;
    assign w_mismatch = (w_exp_len != 8'd0) &&
                        (w_cnt_p1 != {2'b00, w_exp_len});

    // Pairing state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the word to load into the output register.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_word_nxt  = '0;
        w_keep_nxt  = 4'b0000;
        w_last_nxt  = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    if (s_axis_tlast) begin
                        w_load     = 1'b1;
                        w_word_nxt = {{LANE_WIDTH{1'b0}}, w_lane_in};
                        w_keep_nxt = 4'b0011;
                        w_last_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_HALF;
                    end
                end
            end
            ST_HALF: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_word_nxt  = {w_lane_in, w_lane_held};
                    w_keep_nxt  = 4'b1111;
                    w_last_nxt  = s_axis_tlast;
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Lane0 sample waiting for its partner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held <= '0;
        end else if (w_accept && r_state == ST_EMPTY && !s_axis_tlast) begin
            r_held <= s_axis_tdata;
        end
    end

    // Saturating per-packet sample counter and latched expected length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_exp_len <= '0;
        end else if (w_accept) begin
            if (w_first) begin
                r_exp_len <= confi[7:0];
            end
            if (s_axis_tlast) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 9'd1;
            end
        end
    end

    // Output register; holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else if (w_out_ready) begin
            if (w_load) begin
                r_tdata  <= w_word_nxt;
                r_tkeep  <= w_keep_nxt;
                r_tlast  <= w_last_nxt;
                r_tvalid <= 1'b1;
            end else begin
                r_tvalid <= 1'b0;
            end
        end
    end

    // Length error pulse and completed packet counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len_err   <= 1'b0;
            r_pkt_count <= '0;
        end else begin
            r_len_err <= w_accept & s_axis_tlast & w_mismatch;
            if (w_accept && s_axis_tlast) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign len_err       = r_len_err;
    assign pkt_count     = r_pkt_count;

endmodule
